// File: rtl/adc_pkg.sv
// Shared types and default constants for the ADC clock-rate meter.
package adc_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2
    } adc_state_e;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned AVG_LOG2_DEF    = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 10_000_000;
    localparam int unsigned CLK_10M_HZ      = 10_000_000;

    // Bits needed to hold a count of 0..cyc.
    function automatic int unsigned gap_width(input int unsigned cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/adc_edge_sync.sv
// Synchronizes the measured clock into clk_10m, then flags its rising edges.
// The delay flop sits after the synchronizer so that level and rise change together.
module adc_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_10m,
    input  logic rst_n,
    input  logic clk_meas,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise_q;

    // Synchronizer chain, delay flop and registered rising-edge pulse.
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_meas};
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    assign level = dly_q;
    assign rise  = rise_q;

endmodule

// File: rtl/adc_clk_rate_meter.sv
// Measures the returned ADC sample clock: averaged period and high time in clk_10m
// cycles, with a sticky stopped-clock flag.
module adc_clk_rate_meter
    import adc_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk_10m,
    input  logic             rst_n,
    input  logic             clk_meas,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned N_W   = AVG_LOG2 + 1;
    localparam int unsigned GAP_W = gap_width(TIMEOUT_CYC);

    localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    logic level;
    logic rise;

    adc_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_10m (clk_10m),
        .rst_n   (rst_n),
        .clk_meas(clk_meas),
        .level   (level),
        .rise    (rise)
    );

    adc_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] hi_inc;
    logic [ACC_W-1:0] acc_sum;
    logic             gap_hit;

    // State and datapath registers.
    always_ff @(posedge clk_10m) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            per_q     <= '0;
            hi_q      <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            gap_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            hi_q      <= hi_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            gap_q     <= gap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic for the IDLE/ARM/MEASURE sequencer and its counters.
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        acc_d     = acc_q;
        n_d       = n_q;
        gap_d     = gap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        per_inc = (per_q == '1) ? per_q : per_q + 1'b1;
        // High time of a period covers the cycles after its opening edge up to and
        // including its closing edge, so the closing cycle's level is folded in here.
        hi_inc  = (level && hi_q != '1) ? hi_q + 1'b1 : hi_q;
        acc_sum = acc_q + ACC_W'(per_q);
        gap_hit = (gap_q == GAP_LAST);

        unique case (state_q)
            StIdle: begin
                if (meas_en) begin
                    state_d = StArm;
                    gap_d   = '0;
                end
            end
            StArm: begin
                if (!meas_en) begin
                    state_d   = StIdle;
                    timeout_d = 1'b0;
                end else if (rise) begin
                    state_d = StMeasure;
                    per_d   = CNT_W'(1);
                    hi_d    = '0;
                    acc_d   = '0;
                    n_d     = '0;
                    gap_d   = '0;
                end else if (gap_hit) begin
                    timeout_d = 1'b1;
                    gap_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StMeasure: begin
                if (!meas_en) begin
                    state_d   = StIdle;
                    timeout_d = 1'b0;
                end else if (rise) begin
                    // An edge always beats a timeout expiring on the same cycle.
                    per_d = CNT_W'(1);
                    hi_d  = '0;
                    gap_d = '0;
                    if (n_q == N_LAST) begin
                        period_d  = acc_sum[ACC_W-1:AVG_LOG2];
                        high_d    = hi_inc;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        acc_d     = '0;
                        n_d       = '0;
                    end else begin
                        acc_d = acc_sum;
                        n_d   = n_q + 1'b1;
                    end
                end else if (gap_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StArm;
                    gap_d     = '0;
                end else begin
                    per_d = per_inc;
                    hi_d  = hi_inc;
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_adc_clk_rate_meter.sv
// Randomized bench for adc_clk_rate_meter with a timestamp-based reference model.
module tb_adc_clk_rate_meter;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned AVG   = 3;
    localparam int unsigned TMO   = 1000;
    localparam longint      PMAX  = (longint'(1) << CNT_W) - 1;

    logic             clk_10m  = 1'b0;
    logic             rst_n    = 1'b0;
    logic             clk_meas = 1'b0;
    logic             meas_en  = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             timeout;
    logic             busy;

    always #5 clk_10m = ~clk_10m;

    adc_clk_rate_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .AVG_LOG2   (AVG),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_10m     (clk_10m),
        .rst_n       (rst_n),
        .clk_meas    (clk_meas),
        .meas_en     (meas_en),
        .period_out  (period_out),
        .high_out    (high_out),
        .period_valid(period_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (cycle timestamps) ----------------
    int     cyc = 0;
    int     last_rst = -1;
    bit     hist[$];     // pin value sampled at each clk_10m edge
    bit     lvl[$];      // synced level seen by the meter at each edge
    int     mode = 0;    // 0 idle, 1 arm, 2 measure
    int     t_edge = 0;  // edge index of the most recent detected rising edge
    int     gap_start = 0;
    int     n_per = 0;
    longint sum = 0;
    longint m_period = 0, m_high = 0;
    bit     m_valid = 0, m_timeout = 0, model_ready = 0;

    function automatic bit pin_at(input int i);
        if (i < 0 || i <= last_rst) return 1'b0;
        return hist[i];
    endfunction

    always @(posedge clk_10m) begin : model
        int     k;
        bit     l, r;
        longint per, hi;
        k = cyc;
        // The meter sees a pin sample SYNC+1 edges after it was taken.
        l = pin_at(k - 1 - SYNC);
        r = l & !pin_at(k - 2 - SYNC);
        hist.push_back(clk_meas);
        lvl.push_back(l);
        m_valid = 0;
        if (!rst_n) begin
            last_rst  = k;
            mode      = 0;
            m_period  = 0;
            m_high    = 0;
            m_timeout = 0;
            n_per     = 0;
            sum       = 0;
        end else begin
            case (mode)
                0: if (meas_en) begin
                    mode = 1;
                    gap_start = k;
                end
                1: begin
                    if (!meas_en) begin
                        mode = 0;
                        m_timeout = 0;
                    end else if (r) begin
                        mode = 2;
                        t_edge = k;
                        gap_start = k;
                        n_per = 0;
                        sum = 0;
                    end else if (k - gap_start == TMO) begin
                        m_timeout = 1;
                        gap_start = k;
                    end
                end
                default: begin
                    if (!meas_en) begin
                        mode = 0;
                        m_timeout = 0;
                    end else if (r) begin
                        per = k - t_edge;
                        if (per > PMAX) per = PMAX;
                        hi = 0;
                        for (int j = t_edge + 1; j <= k; j++) hi += lvl[j];
                        if (hi > PMAX) hi = PMAX;
                        sum += per;
                        n_per++;
                        if (n_per == (1 << AVG)) begin
                            m_period  = sum >> AVG;
                            m_high    = hi;
                            m_valid   = 1;
                            m_timeout = 0;
                            sum       = 0;
                            n_per     = 0;
                        end
                        t_edge = k;
                        gap_start = k;
                    end else if (k - gap_start == TMO) begin
                        m_timeout = 1;
                        mode = 1;
                        gap_start = k;
                    end
                end
            endcase
        end
        cyc++;
        model_ready = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_10m) begin
        if (model_ready) begin
            cmp("period_out", period_out, m_period);
            cmp("high_out", high_out, m_high);
            cmp("period_valid", period_valid, m_valid);
            cmp("timeout", timeout, m_timeout);
            cmp("busy", busy, (mode != 0));
        end
    end

    // ---------------- clk_meas waveform generator ----------------
    typedef struct {int hi; int lo;} seg_t;
    seg_t pq[$];
    int   wave_hi = 5, wave_lo = 5;
    bit   wave_on = 0;

    task automatic drive_seg(input int h, input int l);
        repeat (h) begin @(posedge clk_10m); #1 clk_meas = 1'b1; end
        repeat (l) begin @(posedge clk_10m); #1 clk_meas = 1'b0; end
    endtask

    initial begin : gen
        seg_t s;
        forever begin
            if (pq.size() > 0) begin
                s = pq.pop_front();
                drive_seg(s.hi, s.lo);
            end else if (wave_on) begin
                drive_seg(wave_hi, wave_lo);
            end else begin
                @(posedge clk_10m);
                #1 clk_meas = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_10m);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_10m);
            if (period_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no period_valid within %0d cycles", name, budget);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int gap;
        step(3);
        rst_n = 1'b1;

        // 1: 10-cycle square wave
        meas_en = 1'b1;
        wave_on = 1;
        wait_valid(300, "s1_first", ok);
        if (ok) begin
            cmp("s1_period", period_out, 10);
            cmp("s1_high", high_out, 5);
        end
        gap = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_10m);
            gap++;
            if (period_valid) break;
        end
        cmp("s1_spacing", gap, 80);

        // 2: alternating 9/11, then a single 11 among 10s
        for (int i = 0; i < 24; i++) begin
            pq.push_back('{5, 4});
            pq.push_back('{5, 6});
        end
        wait_valid(200, "s2_a", ok);
        wait_valid(200, "s2_b", ok);
        cmp("s2_alt_period_b", period_out, 10);
        wait_valid(200, "s2_c", ok);
        cmp("s2_alt_period_c", period_out, 10);
        for (int i = 0; i < 1000 && pq.size() > 0; i++) step(1);
        pq.push_back('{5, 6});
        wait_valid(200, "s2_d", ok);
        cmp("s2_trunc_d", period_out, 10);
        wait_valid(200, "s2_e", ok);
        cmp("s2_trunc_e", period_out, 10);

        // 3: stopped clock, then resume
        wave_on = 0;
        ok = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk_10m);
            if (timeout) begin
                ok = 1;
                break;
            end
        end
        cmp("s3_timeout_set", ok, 1);
        cmp("s3_busy_arm", busy, 1);
        step(1);
        wave_on = 1;
        wait_valid(300, "s3_resume", ok);
        cmp("s3_timeout_cleared", timeout, 0);

        // 4: meas_en dropped mid-window
        wait_valid(200, "s4_pre", ok);
        step(40);
        meas_en = 1'b0;
        @(negedge clk_10m);
        @(negedge clk_10m);
        cmp("s4_busy_low", busy, 0);
        cmp("s4_period_hold", period_out, 10);
        step(50);
        meas_en = 1'b1;
        wait_valid(300, "s4_reenable", ok);
        cmp("s4_period_after", period_out, 10);

        // 5: one-cycle reset mid-window
        step(30);
        rst_n = 1'b0;
        @(negedge clk_10m);
        @(negedge clk_10m);
        cmp("s5_period_zero", period_out, 0);
        cmp("s5_high_zero", high_out, 0);
        cmp("s5_busy_zero", busy, 0);
        rst_n = 1'b1;
        wait_valid(300, "s5_resume", ok);
        cmp("s5_period_resume", period_out, 10);

        // 6: saturation with a 300-cycle period
        wave_hi = 150;
        wave_lo = 150;
        wait_valid(3000, "s6_a", ok);
        wait_valid(3000, "s6_b", ok);
        cmp("s6_sat_period", period_out, 255);
        cmp("s6_high", high_out, 150);

        // 6b: period of exactly TIMEOUT_CYC, edge and expiry coincide
        meas_en = 1'b0;
        step(2);
        meas_en = 1'b1;
        wave_hi = 500;
        wave_lo = 500;
        step(4000);
        cmp("s6_edge_wins_timeout", timeout, 0);
        cmp("s6_edge_wins_busy", busy, 1);

        // Randomized phase
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 9))
                0: begin
                    meas_en = 1'b0;
                    step($urandom_range(1, 20));
                    meas_en = 1'b1;
                end
                1: begin
                    rst_n = 1'b0;
                    step($urandom_range(1, 3));
                    rst_n = 1'b1;
                end
                2: begin
                    wave_on = 0;
                    step($urandom_range(900, 1200));
                    wave_on = 1;
                end
                default: begin
                    wave_hi = $urandom_range(1, 40);
                    wave_lo = $urandom_range(1, 40);
                    for (int p = $urandom_range(2, 6); p > 0; p--)
                        pq.push_back('{$urandom_range(1, 40), $urandom_range(1, 40)});
                end
            endcase
            step($urandom_range(100, 700));
        end
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
